nios2_debug_mem_arbiter: RTL and testbench



---
 rtl/nios2_dbg_pkg.sv | 30 +++
 rtl/nios2_debug_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_nios2_debug_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_dbg_pkg
// Purpose  : Shared types and constants for the Nios II debug memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package nios2_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_JWR  = 3'd1,
    S_JRD  = 3'd2,
    S_JRD2 = 3'd3,
    S_CWR  = 3'd4,
    S_CRD  = 3'd5,
    S_CRD2 = 3'd6
  } state_t;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_LSB = 3;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/nios2_debug_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nios2_debug_mem_arbiter
// Purpose  : Sequences JTAG debug-memory accesses and shares the single-port
//            OCI RAM with the CPU Avalon slave using alternating priority.
// Revision : 1.0 - initial release
// ============================================================================
module nios2_debug_mem_arbiter
  import nios2_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [3:0]        mem_byteen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  state_t              r_state;
  state_t              w_state_nxt;
  grant_t              r_last_grant;
  grant_t              w_grant;
  logic                w_grant_vld;
  logic [ADDR_W-1:0]   r_jaddr;
  logic [31:0]         r_jwdata;
  logic [31:0]         r_mon_dreg;
  logic                r_monitor_ready;
  logic                r_jtag_overrun;
  logic                r_jrd_pend;
  logic                r_jwr_pend;

  logic                w_jbusy;
  logic                w_jload;
  logic                w_jwr_acc;
  logic                w_jrd_acc;
  logic                w_jdrop;
  logic                w_jop_done;
  logic                w_jrd_done;
  logic                w_jreq;
  logic                w_creq;
  logic                w_unused_jdo;

  // Header and trailer bits of the JTAG payload carry nothing for this block.
  assign w_unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign w_jbusy   = r_jrd_pend | r_jwr_pend;
  assign w_jload   = take_action_ocimem_a & ~w_jbusy;
  assign w_jwr_acc = take_action_ocimem_b & ~w_jbusy;
  assign w_jrd_acc = take_no_action_ocimem_a & ~w_jbusy & ~take_action_ocimem_b;
  assign w_jdrop   = w_jbusy ? (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a)
                             : (take_action_ocimem_b & take_no_action_ocimem_a);

  assign w_jreq = w_jbusy;
  assign w_creq = avs_read | avs_write;

  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_monitor_ready;
  assign jtag_overrun  = r_jtag_overrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_last_grant    <= GNT_CPU;
      r_jaddr         <= '0;
      r_jwdata        <= '0;
      r_mon_dreg      <= '0;
      r_monitor_ready <= 1'b0;
      r_jtag_overrun  <= 1'b0;
      r_jrd_pend      <= 1'b0;
      r_jwr_pend      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_vld) begin
        r_last_grant <= w_grant;
      end

      if (w_jload) begin
        r_jaddr        <= jdo[JDO_ADDR_LSB +: ADDR_W];
        r_jtag_overrun <= 1'b0;
      end
      // A drop in the same cycle as an address load still leaves the flag set.
      if (w_jdrop) begin
        r_jtag_overrun <= 1'b1;
      end

      if (w_jwr_acc) begin
        r_jwr_pend      <= 1'b1;
        r_jwdata        <= jdo[JDO_WDATA_LSB +: 32];
        r_monitor_ready <= 1'b0;
      end
      if (w_jrd_acc) begin
        r_jrd_pend      <= 1'b1;
        r_monitor_ready <= 1'b0;
      end

      if (w_jop_done) begin
        r_jaddr         <= r_jaddr + {{(ADDR_W-1){1'b0}}, 1'b1};
        r_jrd_pend      <= 1'b0;
        r_jwr_pend      <= 1'b0;
        r_monitor_ready <= 1'b1;
      end
      if (w_jrd_done) begin
        r_mon_dreg <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_vld     = 1'b0;
    w_grant         = r_last_grant;
    w_jop_done      = 1'b0;
    w_jrd_done      = 1'b0;
    mem_addr        = avs_address;
    mem_wren        = 1'b0;
    mem_byteen      = BE_ALL;
    mem_wdata       = r_jwdata;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;

    case (r_state)
      S_IDLE: begin
        // On a tie the side that did not win last time takes the grant.
        if (w_jreq && (!w_creq || r_last_grant == GNT_CPU)) begin
          w_grant_vld = 1'b1;
          w_grant     = GNT_JTAG;
          w_state_nxt = r_jwr_pend ? S_JWR : S_JRD;
        end else if (w_creq) begin
          w_grant_vld = 1'b1;
          w_grant     = GNT_CPU;
          w_state_nxt = avs_write ? S_CWR : S_CRD;
        end
      end
      S_JWR: begin
        mem_addr    = r_jaddr;
        mem_wren    = 1'b1;
        w_jop_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_JRD: begin
        mem_addr    = r_jaddr;
        w_state_nxt = S_JRD2;
      end
      S_JRD2: begin
        w_jop_done  = 1'b1;
        w_jrd_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_CWR: begin
        mem_byteen      = avs_byteenable;
        mem_wdata       = avs_writedata;
        mem_wren        = debugack;
        avs_waitrequest = 1'b0;
        w_state_nxt     = S_IDLE;
      end
      S_CRD: begin
        w_state_nxt = S_CRD2;
      end
      S_CRD2: begin
        avs_readdata    = mem_rdata;
        avs_waitrequest = 1'b0;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_debug_mem_arbiter
// Purpose  : Directed self-checking bench with a transaction-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_debug_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic        debugack;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  mem_addr;
  logic        mem_wren;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;

  always #5 clk = ~clk;

  nios2_debug_mem_arbiter #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .debugack                (debugack),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .mem_addr                (mem_addr),
    .mem_wren                (mem_wren),
    .mem_byteen              (mem_byteen),
    .mem_wdata               (mem_wdata),
    .mem_rdata               (mem_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  // Debug RAM: byte-enabled write, one-cycle registered read.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byteen[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct packed { logic [7:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  typedef struct packed { logic is_rd; logic [31:0] data; } op_t;

  wr_t         wr_q[$];
  op_t         op_q[$];
  logic [31:0] exp_mem [256];
  logic [7:0]  model_jaddr;
  logic [31:0] exp_mon;
  logic        prev_ready;
  wr_t         cmp_w;
  op_t         cmp_o;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic jtag_load(input logic [7:0] a);
    jdo = '0;
    jdo[24:17] = a;
    jdo[37:35] = 3'b110;
    jdo[2:0]   = 3'b011;
    model_jaddr = a;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_strobe(input bit wr, input logic [31:0] d);
    op_t o;
    if (wr) begin
      wr_q.push_back('{addr: model_jaddr, data: d, be: 4'hF});
      exp_mem[model_jaddr] = d;
      o = '{is_rd: 1'b0, data: d};
    end else begin
      o = '{is_rd: 1'b1, data: exp_mem[model_jaddr]};
    end
    op_q.push_back(o);
    model_jaddr = model_jaddr + 8'd1;
    jdo = {3'b101, d, 3'b010};
    if (wr) take_action_ocimem_b = 1'b1;
    else    take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      smp();
      if (monitor_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    chk({name, " ready wait"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic cpu_access(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output int lat, output logic c_wren,
                            output logic [3:0] c_be, output logic [31:0] c_rdata);
    lat = -1; c_wren = 1'b0; c_be = 4'h0; c_rdata = 32'h0;
    if (wr && debugack) begin
      wr_q.push_back('{addr: a, data: d, be: be});
      for (int i = 0; i < 4; i++) begin
        if (be[i]) exp_mem[a][8*i +: 8] = d[8*i +: 8];
      end
    end
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    avs_write = wr; avs_read = !wr;
    for (int k = 0; k < 40; k++) begin
      smp();
      if (avs_waitrequest === 1'b0) begin
        lat = k; c_wren = mem_wren; c_be = mem_byteen; c_rdata = avs_readdata;
        break;
      end
      tick();
    end
    tick();
    avs_write = 1'b0; avs_read = 1'b0;
    chk("cpu access completes", {31'd0, lat >= 0}, 32'd1);
  endtask

  // Continuous comparison against the transaction model.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_mon    = 32'h0;
      prev_ready = 1'b0;
    end else begin
      if (mem_wren === 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("unexpected mem_wren", {31'd0, mem_wren}, 32'd0);
        end else begin
          cmp_w = wr_q.pop_front();
          chk("mem write addr", {24'd0, mem_addr}, {24'd0, cmp_w.addr});
          chk("mem write data", mem_wdata, cmp_w.data);
          chk("mem write be", {28'd0, mem_byteen}, {28'd0, cmp_w.be});
        end
      end
      if (avs_read === 1'b1 && avs_waitrequest === 1'b0) begin
        chk("avs_readdata", avs_readdata, exp_mem[avs_address]);
      end
      if (monitor_ready === 1'b1 && !prev_ready) begin
        if (op_q.size() == 0) begin
          chk("unexpected monitor_ready", {31'd0, monitor_ready}, 32'd0);
        end else begin
          cmp_o = op_q.pop_front();
          if (cmp_o.is_rd) exp_mon = cmp_o.data;
        end
      end
      chk("MonDReg", MonDReg, exp_mon);
      prev_ready = monitor_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        c_wren;
    logic [3:0]  c_be;
    logic [31:0] c_rd;

    reset_n = 1'b0; jdo = '0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    debugack = 1'b0; avs_address = 8'h33; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'h0; avs_byteenable = 4'hF; model_jaddr = 8'h0;
    repeat (3) @(posedge clk);
    smp();
    chk("rst avs_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
    chk("rst mem_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst MonDReg", MonDReg, 32'h0);
    chk("rst monitor_ready", {31'd0, monitor_ready}, 32'd0);
    chk("rst jtag_overrun", {31'd0, jtag_overrun}, 32'd0);
    tick();
    reset_n = 1'b1;

    // JTAG write timing: strobe cycle 0, mem_wren cycle 2, ready from cycle 3.
    jtag_load(8'h10);
    jtag_strobe(1'b1, 32'hDEADBEEF);
    smp(); chk("jwr c1 mem_wren", {31'd0, mem_wren}, 32'd0);
    tick(); smp();
    chk("jwr c2 mem_wren", {31'd0, mem_wren}, 32'd1);
    chk("jwr c2 mem_addr", {24'd0, mem_addr}, 32'h10);
    chk("jwr c2 mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("jwr c2 mem_byteen", {28'd0, mem_byteen}, 32'hF);
    chk("jwr c2 monitor_ready", {31'd0, monitor_ready}, 32'd0);
    tick(); smp();
    chk("jwr c3 monitor_ready", {31'd0, monitor_ready}, 32'd1);
    tick();
    jtag_strobe(1'b1, 32'h0BADF00D);
    wait_ready("jwr 0x11");

    // Preload 0xFF=1 and 0x00=2 across the wrap, then read both back.
    jtag_load(8'hFF);
    jtag_strobe(1'b1, 32'h1); wait_ready("pre ff");
    jtag_strobe(1'b1, 32'h2); wait_ready("pre 00");
    jtag_load(8'hFF);
    jtag_strobe(1'b0, 32'h0);
    smp(); chk("jrd c1 ready cleared", {31'd0, monitor_ready}, 32'd0);
    tick(); smp(); chk("jrd c2 mem_addr", {24'd0, mem_addr}, 32'hFF);
    tick(); smp(); chk("jrd c3 monitor_ready", {31'd0, monitor_ready}, 32'd0);
    tick(); smp();
    chk("jrd c4 monitor_ready", {31'd0, monitor_ready}, 32'd1);
    chk("jrd c4 MonDReg", MonDReg, 32'h1);
    tick();
    jtag_strobe(1'b0, 32'h0); wait_ready("jrd wrap");
    chk("jrd wrap MonDReg", MonDReg, 32'h2);

    // CPU writes: debugack gates the memory write, completion is unaffected.
    jtag_load(8'h20);
    jtag_strobe(1'b1, 32'hCAFEF00D); wait_ready("pre 20");
    debugack = 1'b0;
    cpu_access(1'b1, 8'h20, 32'h12345678, 4'hF, lat, c_wren, c_be, c_rd);
    chk("cwr nodack latency", lat, 32'd1);
    chk("cwr nodack mem_wren", {31'd0, c_wren}, 32'd0);
    cpu_access(1'b0, 8'h20, 32'h0, 4'hF, lat, c_wren, c_be, c_rd);
    chk("crd latency", lat, 32'd2);
    chk("crd unchanged", c_rd, 32'hCAFEF00D);
    debugack = 1'b1;
    cpu_access(1'b1, 8'h20, 32'h12345678, 4'b0101, lat, c_wren, c_be, c_rd);
    chk("cwr dack latency", lat, 32'd1);
    chk("cwr dack mem_wren", {31'd0, c_wren}, 32'd1);
    chk("cwr dack mem_byteen", {28'd0, c_be}, 32'h5);
    cpu_access(1'b0, 8'h20, 32'h0, 4'hF, lat, c_wren, c_be, c_rd);
    chk("crd merged", c_rd, 32'hCA34F078);

    // Second read strobe while one is pending is dropped.
    jtag_load(8'h10);
    jtag_strobe(1'b0, 32'h0);
    take_no_action_ocimem_a = 1'b1; tick(); take_no_action_ocimem_a = 1'b0;
    smp(); chk("overrun set", {31'd0, jtag_overrun}, 32'd1);
    tick(); wait_ready("ovr rd");
    chk("ovr MonDReg", MonDReg, 32'hDEADBEEF);
    jtag_strobe(1'b0, 32'h0); wait_ready("ovr next");
    chk("ovr jaddr once", MonDReg, 32'h0BADF00D);
    chk("overrun sticky", {31'd0, jtag_overrun}, 32'd1);
    jtag_load(8'h40);
    smp(); chk("load clears overrun", {31'd0, jtag_overrun}, 32'd0);
    tick();

    // Write and read strobes together: write wins, read dropped.
    wr_q.push_back('{addr: 8'h40, data: 32'h77777777, be: 4'hF});
    exp_mem[8'h40] = 32'h77777777;
    op_q.push_back('{is_rd: 1'b0, data: 32'h77777777});
    model_jaddr = 8'h41;
    jdo = {3'b000, 32'h77777777, 3'b000};
    take_action_ocimem_b = 1'b1; take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    smp(); chk("wr+rd overrun", {31'd0, jtag_overrun}, 32'd1);
    tick(); wait_ready("wr+rd");

    // Reset while a CPU read sits in CRD.
    avs_address = 8'h20; avs_read = 1'b1;
    tick(); smp();
    chk("crd waitrequest", {31'd0, avs_waitrequest}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst waitrequest", {31'd0, avs_waitrequest}, 32'd1);
    chk("mid rst mem_wren", {31'd0, mem_wren}, 32'd0);
    chk("mid rst MonDReg", MonDReg, 32'h0);
    chk("mid rst monitor_ready", {31'd0, monitor_ready}, 32'd0);
    chk("mid rst jtag_overrun", {31'd0, jtag_overrun}, 32'd0);
    avs_read = 1'b0;
    wr_q.delete(); op_q.delete();
    model_jaddr = 8'h0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Tie from reset: JTAG wins (arbitration cycle t), CPU done at t+4.
    jtag_strobe(1'b1, 32'h55AA55AA);
    cpu_access(1'b0, 8'h20, 32'h0, 4'hF, lat, c_wren, c_be, c_rd);
    chk("tie1 cpu latency", lat, 32'd4);
    chk("tie1 cpu data", c_rd, 32'hCA34F078);
    wait_ready("tie1 jwr");

    // JTAG granted last, so the next tie goes to the CPU.
    jtag_strobe(1'b1, 32'h11111111); wait_ready("tie2 pre");
    jtag_load(8'h00);
    jtag_strobe(1'b0, 32'h0);
    cpu_access(1'b0, 8'h20, 32'h0, 4'hF, lat, c_wren, c_be, c_rd);
    chk("tie2 cpu latency", lat, 32'd2);
    wait_ready("tie2 jrd");
    chk("tie2 MonDReg", MonDReg, 32'h55AA55AA);

    repeat (3) tick();
    chk("write queue drained", wr_q.size(), 32'd0);
    chk("op queue drained", op_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
